rsa_operand_fetch: RTL and testbench

RSA_OPERAND_FETCH -- requirements
Module: rsa_operand_fetch

---
 rtl/rsa_operand_fetch.sv | 189 ++++++++++++++++++
 tb/tb_rsa_operand_fetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_fetch.sv
// Operand fetch engine: issues Avalon-MM word reads and streams the returned words out in order.
// Define RSA_FETCH_BYTESWAP_EN to byte-reverse every delivered word (latency unchanged).
module rsa_operand_fetch #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_read,
  input  logic              avm_m0_waitrequest,
  input  logic [DATA_W-1:0] avm_m0_readdata,
  input  logic              avm_m0_readdatavalid,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]        state;
  logic [15:0]       total;
  logic [15:0]       issued;
  logic [15:0]       popped;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W:0]    in_flight;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] head;

  logic active;
  logic credit_ok;
  logic accept;
  logic rsp;
  logic push;
  logic pop;
  logic last_pop;
  logic flush_now;

  assign active    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign flush_now = active && abort;

  // Reads in flight plus buffered words never exceed the buffer, so every response has a slot.
  assign in_flight = {1'b0, outstanding} + {1'b0, occupancy};
  assign credit_ok = in_flight < (CNT_W+1)'(FIFO_DEPTH);

  assign avm_m0_read = (state == ST_ISSUE) && !abort && (issued != total) && credit_ok;
  assign accept      = avm_m0_read && !avm_m0_waitrequest;
  assign rsp         = avm_m0_readdatavalid && (outstanding != '0);
  assign push        = rsp && active && !abort;

  assign out_valid = active && !abort && (occupancy != '0);
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (popped == total - 16'd1);
  assign last_pop  = pop && out_last;
  assign busy      = (state != ST_IDLE);

  assign head = mem[rd_ptr];

`ifdef RSA_FETCH_BYTESWAP_EN
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      out_data[8*i +: 8] = head[8*(BYTES-1-i) +: 8];
    end
  end
`else
  assign out_data = head;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= avm_m0_readdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush_now) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        occupancy <= occupancy + CNT_W'(1);
      end else if (pop && !push) begin
        occupancy <= occupancy - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else if (accept && !rsp) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (rsp && !accept) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      total          <= '0;
      issued         <= '0;
      popped         <= '0;
      avm_m0_address <= '0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        avm_m0_address <= avm_m0_address + ADDR_STEP;
        issued         <= issued + 16'd1;
      end
      if (pop) begin
        popped <= popped + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              state          <= ST_ISSUE;
              total          <= word_count;
              avm_m0_address <= base_addr;
              issued         <= '0;
              popped         <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            state <= ST_FLUSH;
          end else if (last_pop) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (accept && (issued == total - 16'd1)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state <= ST_FLUSH;
          end else if (last_pop) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          // Leave as soon as the final discarded response lands, not a cycle later.
          if ((outstanding == '0) || ((outstanding == CNT_W'(1)) && rsp)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_operand_fetch.sv
// Scoreboard bench for rsa_operand_fetch: Avalon slave model with random stalls/latency, stream monitor.
`timescale 1ns/1ps
module tb_rsa_operand_fetch;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 256;
  localparam int FIFO_DEPTH = 8;
  localparam int BYTES      = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       word_count;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_m0_address;
  logic              avm_m0_read;
  logic              avm_m0_waitrequest;
  logic [DATA_W-1:0] avm_m0_readdata;
  logic              avm_m0_readdatavalid;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  always #5 clk = ~clk;

  rsa_operand_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .abort(abort), .busy(busy), .done(done), .avm_m0_address(avm_m0_address),
    .avm_m0_read(avm_m0_read), .avm_m0_waitrequest(avm_m0_waitrequest),
    .avm_m0_readdata(avm_m0_readdata), .avm_m0_readdatavalid(avm_m0_readdatavalid),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  typedef struct { logic [DATA_W-1:0] data; logic last; } exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; int due; } pend_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  pend_t             pend[$];

  int errors = 0, checks = 0, cyc = 0;
  int acc_cnt = 0, pop_cnt = 0, rsp_cnt = 0, done_cnt = 0;
  int wait_pct = 0, lat_min = 1, lat_max = 1, ready_pct = 100;
  bit ready_low = 0;
  int stall_idx = -1, stall_len = 0, stall_done = 0, stall_seen = 0;
  bit zero_cmd = 0;
  int start_cyc = 0, last_pop_cyc = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents seen by the master; 0x2000 holds the byte-index pattern.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    if (a == 32'h2000) begin
      for (int i = 0; i < BYTES; i++) w[8*i +: 8] = 8'(i);
    end else begin
      for (int k = 0; k < DATA_W/32; k++) w[32*k +: 32] = (a ^ 32'h5A5A_0000) * 32'(2*k+1) + 32'(k);
    end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] expect_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w, r;
    w = mem_word(a);
`ifdef RSA_FETCH_BYTESWAP_EN
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = w[8*(BYTES-1-i) +: 8];
`else
    r = w;
`endif
    return r;
  endfunction

  // Avalon slave + out_ready driver: decides inputs at each negedge for the following posedge.
  initial begin : bus
    logic wr, hold_pending;
    logic [ADDR_W-1:0] hold_addr;
    hold_pending = 0;
    hold_addr = '0;
    avm_m0_waitrequest = 0;
    avm_m0_readdatavalid = 0;
    avm_m0_readdata = '0;
    out_ready = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (hold_pending) begin
        check("hold_read", avm_m0_read, 1);
        check("hold_addr", avm_m0_address, hold_addr);
      end
      if (avm_m0_read && (stall_idx == acc_cnt) && (stall_done < stall_len)) begin
        wr = 1;
        stall_done++;
        if (avm_m0_address == 32'h1020) stall_seen++;
      end else begin
        wr = ($urandom_range(99) < wait_pct);
      end
      avm_m0_waitrequest = wr;
      hold_pending = avm_m0_read && wr;
      hold_addr = avm_m0_address;
      if (avm_m0_read && !wr) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: address %h accepted, none expected", avm_m0_address);
        end else begin
          check("read_addr", avm_m0_address, addr_q.pop_front());
        end
        pend.push_back('{addr: avm_m0_address, due: cyc + int'($urandom_range(lat_max, lat_min))});
        acc_cnt++;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        avm_m0_readdatavalid = 1;
        avm_m0_readdata = mem_word(pend[0].addr);
        void'(pend.pop_front());
        rsp_cnt++;
      end else begin
        avm_m0_readdatavalid = 0;
        avm_m0_readdata = {8{$urandom}};
      end
      out_ready = ready_low ? 1'b0 : ($urandom_range(99) < ready_pct);
    end
  end

  // Stream monitor: compares the presented head against the scoreboard and tracks done.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (done) begin
        done_cnt++;
        check("done_no_pending_words", exp_q.size(), 0);
        if (zero_cmd) check("done_zero_timing", cyc, start_cyc + 1);
        else          check("done_timing", cyc, last_pop_cyc + 1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: out_data %h presented, none expected", out_data);
        end else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            e = exp_q.pop_front();
            pop_cnt++;
            if (e.last) last_pop_cyc = cyc;
          end
        end
      end else if (out_last) begin
        check("last_without_valid", out_last, 0);
      end
      if (busy) check("credit_limit", (acc_cnt - pop_cnt) <= FIFO_DEPTH, 1);
    end
  end

  task automatic issue_cmd(input logic [ADDR_W-1:0] base, input logic [15:0] wc, input logic with_abort);
    for (int i = 0; i < int'(wc); i++) begin
      addr_q.push_back(base + 32'(i) * 32'd32);
      exp_q.push_back('{data: expect_word(base + 32'(i) * 32'd32), last: (i == int'(wc) - 1)});
    end
    acc_cnt = 0; pop_cnt = 0; rsp_cnt = 0;
    zero_cmd = (wc == 0);
    @(posedge clk); #1;
    start = 1; base_addr = base; word_count = wc; abort = with_abort;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 0; abort = 0; base_addr = $urandom; word_count = 16'($urandom);
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin @(posedge clk); n++; end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
    end
    @(negedge clk); #2;
    check({name, "_busy_after"}, busy, 0);
    check({name, "_words_left"}, exp_q.size(), 0);
    check({name, "_reads_left"}, addr_q.size(), 0);
  endtask

  task automatic run_cmd(input string name, input logic [ADDR_W-1:0] base, input logic [15:0] wc,
                         input logic extra_start);
    int d0 = done_cnt;
    issue_cmd(base, wc, 0);
    if (extra_start) begin
      repeat (2) @(posedge clk);
      #1; start = 1; base_addr = 32'hDEAD_0000; word_count = 16'd3;
      @(posedge clk); #1; start = 0;
    end
    wait_done(name, d0);
  endtask

  initial begin : stim
    int d0, n;
    reset = 1; start = 0; abort = 0; base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", avm_m0_read, 0);
    check("rst_addr", avm_m0_address, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    @(posedge clk); #1; reset = 0;

    // Basic fetch, fixed latency 3, no stalls, always ready.
    wait_pct = 0; lat_min = 3; lat_max = 3; ready_pct = 100;
    run_cmd("basic", 32'h1000, 16'd4, 0);

    // Zero-length command: immediate done, never busy, no reads.
    d0 = done_cnt;
    issue_cmd(32'h4000, 16'd0, 0);
    repeat (3) begin
      @(negedge clk); #2;
      check("zero_busy", busy, 0);
      check("zero_read", avm_m0_read, 0);
    end
    check("zero_done_once", done_cnt, d0 + 1);
    check("zero_no_reads", acc_cnt, 0);

    // Backpressure: only FIFO_DEPTH reads outstanding until the sink drains.
    lat_min = 1; lat_max = 4; ready_low = 1;
    d0 = done_cnt;
    issue_cmd(32'h0008_0000, 16'd20, 0);
    repeat (40) @(posedge clk);
    #1;
    check("bp_reads_capped", acc_cnt, FIFO_DEPTH);
    check("bp_read_low", avm_m0_read, 0);
    ready_low = 0;
    wait_done("backpressure", d0);
    check("bp_all_reads", acc_cnt, 20);

    // Stall the second read for 5 cycles.
    lat_min = 2; lat_max = 2; stall_idx = 1; stall_len = 5; stall_done = 0; stall_seen = 0;
    run_cmd("stall", 32'h1000, 16'd4, 0);
    check("stall_cycles_at_1020", stall_seen, 5);
    stall_idx = -1;

    // Abort after three accepted reads with responses still in flight.
    lat_min = 2; lat_max = 2; ready_low = 1;
    d0 = done_cnt;
    issue_cmd(32'h3000, 16'd10, 0);
    n = 0;
    while (acc_cnt < 3 && n < 100) begin @(posedge clk); n++; end
    #1;
    check("abort_reached_3_reads", acc_cnt, 3);
    abort = 1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1; abort = 0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk); #2;
      check("flush_out_valid", out_valid, 0);
      check("flush_read", avm_m0_read, 0);
      n++;
    end
    check("flush_exit", busy, 0);
    check("flush_all_rsp_returned", rsp_cnt, 3);
    check("flush_reads_total", acc_cnt, 3);
    check("abort_no_done", done_cnt, d0);
    ready_low = 0;

    // Abort while idle does nothing.
    @(posedge clk); #1; abort = 1;
    repeat (2) @(posedge clk);
    #1; check("idle_abort_busy", busy, 0);
    abort = 0;

    // Start wins over a simultaneous abort.
    d0 = done_cnt;
    issue_cmd(32'h5000, 16'd3, 1);
    wait_done("start_with_abort", d0);

    // Address wraps at the top of the address space.
    lat_min = 1; lat_max = 3;
    run_cmd("wrap", 32'hFFFF_FFC0, 16'd4, 0);

    // Byte-index pattern word.
    run_cmd("bytepattern", 32'h0000_2000, 16'd1, 0);

    // Randomised commands, with a stray start while busy on some.
    for (int t = 0; t < 10; t++) begin
      wait_pct  = int'($urandom_range(40));
      lat_min   = int'($urandom_range(3, 1));
      lat_max   = lat_min + int'($urandom_range(4));
      ready_pct = int'($urandom_range(100, 30));
      run_cmd("random", $urandom, 16'($urandom_range(24, 8)), (t % 2) == 0);
    end
    wait_pct = 0;
    run_cmd("random_b2b", $urandom, 16'd16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
